// File: rtl/updown_ctrl_if.sv
// -----------------------------------------------------------------------------
// updown_ctrl_if
// Purpose : groups the request/acknowledge handshake and the counter status
//           of updown_ctrl into one bundle.
// Signals :
//   up_req  - requester asks for one +UP_STEP operation, held until ack_up
//   dn_req  - requester asks for one -DN_STEP operation, held until ack_dn
//   ack_up  - one-cycle completion pulse for an up request
//   ack_dn  - one-cycle completion pulse for a down request
//   rej     - meaningful only with an ack; 1 = refused by the bound check
//   busy    - controller is working on an operation
//   count   - current 16-bit counter value
//   rej_cnt - saturating refusal counter (only with UPDOWN_CTRL_STAT_EN)
// Modports: master = requester side, slave = controller side.
//
// Handshake: a requester raises its req and keeps it high until it sees the
// matching ack pulse. Each ack retires exactly one request. A req still high
// after its ack is taken as a fresh request.
// -----------------------------------------------------------------------------
interface updown_ctrl_if;
   logic        up_req;
   logic        dn_req;
   logic        ack_up;
   logic        ack_dn;
   logic        rej;
   logic        busy;
   logic [15:0] count;
`ifdef UPDOWN_CTRL_STAT_EN
   logic [7:0]  rej_cnt;

   modport master (output up_req, output dn_req,
                   input ack_up, input ack_dn, input rej, input busy,
                   input count, input rej_cnt);
   modport slave  (input up_req, input dn_req,
                   output ack_up, output ack_dn, output rej, output busy,
                   output count, output rej_cnt);
`else
   modport master (output up_req, output dn_req,
                   input ack_up, input ack_dn, input rej, input busy,
                   input count);
   modport slave  (input up_req, input dn_req,
                   output ack_up, output ack_dn, output rej, output busy,
                   output count);
`endif
endinterface

// File: rtl/updown_ctrl.sv
// -----------------------------------------------------------------------------
// updown_ctrl
// Purpose : bounded up/down counter arbitrated between two requesters.
//           One operation takes three cycles (IDLE -> STEP -> DONE). Ties
//           between requesters alternate so that neither side starves.
// Ports   :
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-low reset
//   bus       - updown_ctrl_if.slave (requests, acks, rej, busy, count and,
//               optionally, rej_cnt)
//   state_dbg - current FSM state (IDLE=0, STEP=1, DONE=2)
// Build option:
//   UPDOWN_CTRL_STAT_EN - adds the saturating 8-bit refusal counter rej_cnt.
// -----------------------------------------------------------------------------
module updown_ctrl #(
   parameter int unsigned UP_STEP  = 18,
   parameter int unsigned DN_STEP  = 27,
   parameter int unsigned INIT_VAL = 200,
   parameter int unsigned MAX_VAL  = 1000,
   parameter int unsigned MIN_VAL  = 0
) (
   input  logic               clk,
   input  logic               rst,
   updown_ctrl_if.slave       bus,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bound checks are done at 17 bits so neither side can wrap around.
   localparam logic [16:0] UP_W   = 17'(UP_STEP);
   localparam logic [16:0] DN_W   = 17'(DN_STEP);
   localparam logic [16:0] MAX_W  = 17'(MAX_VAL);
   localparam logic [16:0] MIN_W  = 17'(MIN_VAL);
   localparam logic [15:0] UP_16  = 16'(UP_STEP);
   localparam logic [15:0] DN_16  = 16'(DN_STEP);
   localparam logic [15:0] INIT_16 = 16'(INIT_VAL);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic        win_up_q, win_up_d;    // winner of the operation in flight
   logic        last_up_q, last_up_d;  // last winner; 0 = down, so first tie goes up
   logic        rej_q, rej_d;          // refusal result shown during DONE
   logic        acc_up, acc_dn;

   // Adding to the count rather than subtracting from MAX_VAL keeps the
   // check correct even when UP_STEP exceeds MAX_VAL.
   assign acc_up = ({1'b0, count_q} + UP_W) <= MAX_W;
   assign acc_dn = {1'b0, count_q} >= (MIN_W + DN_W);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         count_q   <= INIT_16;
         win_up_q  <= 1'b0;
         last_up_q <= 1'b0;
         rej_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         win_up_q  <= win_up_d;
         last_up_q <= last_up_d;
         rej_q     <= rej_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      win_up_d  = win_up_q;
      last_up_d = last_up_q;
      rej_d     = rej_q;
      case (state_q)
         IDLE: begin
            if (bus.up_req || bus.dn_req) begin
               // On a tie the side that did not win last time goes next.
               if (bus.up_req && bus.dn_req) begin
                  win_up_d = ~last_up_q;
               end else begin
                  win_up_d = bus.up_req;
               end
               last_up_d = win_up_d;
               state_d   = STEP;
            end
         end
         STEP: begin
            if (win_up_q) begin
               rej_d = ~acc_up;
               if (acc_up) begin
                  count_d = count_q + UP_16;
               end
            end else begin
               rej_d = ~acc_dn;
               if (acc_dn) begin
                  count_d = count_q - DN_16;
               end
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode registered state only, so they drop to zero the moment
   // reset forces the state back to IDLE.
   always_comb begin
      bus.ack_up = (state_q == DONE) &&  win_up_q;
      bus.ack_dn = (state_q == DONE) && !win_up_q;
      bus.rej    = (state_q == DONE) &&  rej_q;
      bus.busy   = (state_q != IDLE);
      bus.count  = count_q;
      state_dbg  = state_q;
   end

`ifdef UPDOWN_CTRL_STAT_EN
   logic [7:0] rej_cnt_q, rej_cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rej_cnt_q <= 8'd0;
      end else begin
         rej_cnt_q <= rej_cnt_d;
      end
   end

   always_comb begin
      rej_cnt_d = rej_cnt_q;
      if ((state_q == DONE) && rej_q && (rej_cnt_q != 8'hFF)) begin
         rej_cnt_d = rej_cnt_q + 8'd1;
      end
   end

   assign bus.rej_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_updown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_ctrl
// Directed bench for updown_ctrl. A transaction-level model turns each
// accepted request into the three per-cycle output snapshots it must produce
// and queues them; a compare process checks every cycle against the head of
// that schedule. Literal expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_updown_ctrl;

   localparam int UP   = 18;
   localparam int DN   = 27;
   localparam int INIT = 200;
   localparam int MAXV = 1000;
   localparam int MINV = 0;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   updown_ctrl_if bus_if ();

   updown_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .state_dbg (state_dbg)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at t=%0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Snapshot layout: {count[15:0], busy, ack_up, ack_dn, rej}
   logic [19:0] exp_q[$];
   logic [19:0] cur_exp;
   int          m_count;
   bit          m_last_up;
   int          m_rej_cnt;
   bit          m_win_up;
   bit          m_ok;
   int          m_nc;

   function automatic logic [19:0] snap(input int c, input bit b, input bit au,
                                        input bit ad, input bit rj);
      logic [15:0] c16;
      c16 = c[15:0];
      return {c16, b, au, ad, rj};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         m_count   = INIT;
         m_last_up = 1'b0;
         m_rej_cnt = 0;
         cur_exp   = snap(INIT, 0, 0, 0, 0);
      end else begin
         if (cur_exp[0] && m_rej_cnt < 255) m_rej_cnt++;
         if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
         end else if (bus_if.up_req || bus_if.dn_req) begin
            m_win_up  = (bus_if.up_req && bus_if.dn_req) ? !m_last_up : bus_if.up_req;
            m_last_up = m_win_up;
            m_ok = m_win_up ? (m_count + UP <= MAXV) : (m_count - DN >= MINV);
            m_nc = !m_ok ? m_count : (m_win_up ? m_count + UP : m_count - DN);
            cur_exp = snap(m_count, 1, 0, 0, 0);
            exp_q.push_back(snap(m_nc, 1, m_win_up, !m_win_up, !m_ok));
            exp_q.push_back(snap(m_nc, 0, 0, 0, 0));
            m_count = m_nc;
         end else begin
            cur_exp = snap(m_count, 0, 0, 0, 0);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [19:0] act_vec;
   always @(negedge clk) begin
      act_vec = {bus_if.count, bus_if.busy, bus_if.ack_up, bus_if.ack_dn, bus_if.rej};
      check("cycle", {12'd0, act_vec}, {12'd0, cur_exp});
`ifdef UPDOWN_CTRL_STAT_EN
      check("rej_cnt_cycle", {24'd0, bus_if.rej_cnt}, m_rej_cnt);
`endif
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      bus_if.up_req = 1'b0;
      bus_if.dn_req = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   task automatic wait_ack(output bit au, output bit ad, output bit rj);
      au = 0; ad = 0; rj = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus_if.ack_up || bus_if.ack_dn) begin
            au = bus_if.ack_up;
            ad = bus_if.ack_dn;
            rj = bus_if.rej;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected one within 12 cycles at t=%0t", $time);
   endtask

   // One complete operation; returns at the negedge of the ack cycle.
   task automatic do_op(input bit up, output bit rj);
      bit au, ad;
      @(negedge clk);
      if (up) bus_if.up_req = 1'b1;
      else    bus_if.dn_req = 1'b1;
      wait_ack(au, ad, rj);
      bus_if.up_req = 1'b0;
      bus_if.dn_req = 1'b0;
      check(up ? "op_ack_up" : "op_ack_dn", up ? au : ad, 1);
   endtask

   // Holds both requests and checks the order and counts of n acks.
   task automatic tie_run(input int n, input bit first_up, input int start_cnt);
      bit au, ad, rj;
      bit want_up;
      int want_cnt;
      want_up  = first_up;
      want_cnt = start_cnt;
      @(negedge clk);
      bus_if.up_req = 1'b1;
      bus_if.dn_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         wait_ack(au, ad, rj);
         want_cnt = want_up ? want_cnt + UP : want_cnt - DN;
         check("tie_winner_up", au, want_up);
         check("tie_count", bus_if.count, want_cnt);
         want_up = !want_up;
      end
      bus_if.up_req = 1'b0;
      bus_if.dn_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   bit rj;
   bit saw_ack;

   initial begin
      bus_if.up_req = 1'b0;
      bus_if.dn_req = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;

      // Idle after reset release.
      repeat (6) @(negedge clk);
      check("idle_count", bus_if.count, 200);
      check("idle_busy", bus_if.busy, 0);
      check("idle_acks", {bus_if.ack_up, bus_if.ack_dn}, 0);

      // Single up, walked cycle by cycle.
      bus_if.up_req = 1'b1;
      @(negedge clk);
      check("single_step_busy", bus_if.busy, 1);
      check("single_step_count", bus_if.count, 200);
      @(negedge clk);
      check("single_count", bus_if.count, 218);
      check("single_ack_up", bus_if.ack_up, 1);
      check("single_rej", bus_if.rej, 0);
      check("single_busy", bus_if.busy, 1);
      bus_if.up_req = 1'b0;
      @(negedge clk);
      check("single_after_busy", bus_if.busy, 0);
      check("single_after_ack", bus_if.ack_up, 0);
      check("model_single", m_count, 218);

      // Eight downs from 200: seventh lands on 11, eighth refused.
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         do_op(1'b0, rj);
         if (i < 7) check("dn_rej", rj, 0);
         if (i == 6) check("dn_count_7", bus_if.count, 11);
         if (i == 7) begin
            check("dn_rej_8", rj, 1);
            check("dn_count_8", bus_if.count, 11);
         end
      end
      check("model_dn", m_count, 11);
`ifdef UPDOWN_CTRL_STAT_EN
      @(negedge clk);
      check("rej_cnt_dn", {24'd0, bus_if.rej_cnt}, 1);
`endif

      // 45 ups from 200: 44th lands on 992, 45th refused.
      apply_reset();
      for (int i = 0; i < 45; i++) begin
         do_op(1'b1, rj);
         if (i == 43) check("up_count_44", bus_if.count, 992);
         if (i == 44) begin
            check("up_rej_45", rj, 1);
            check("up_count_45", bus_if.count, 992);
         end
      end
      check("model_up", m_count, 992);

      // Both held from reset: up first, then alternate.
      apply_reset();
      tie_run(4, 1'b1, 200);

      // After an up win, the next tie goes to down.
      apply_reset();
      do_op(1'b1, rj);
      tie_run(2, 1'b0, 218);

      // Reset while an up request sits in STEP.
      apply_reset();
      @(negedge clk);
      bus_if.up_req = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      bus_if.up_req = 1'b0;
      #1;
      check("abort_busy", bus_if.busy, 0);
      check("abort_count", bus_if.count, 200);
      check("abort_ack_up", bus_if.ack_up, 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      saw_ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus_if.ack_up || bus_if.ack_dn) saw_ack = 1'b1;
      end
      check("abort_no_ack", saw_ack, 0);
      check("abort_final_count", bus_if.count, 200);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish by t=200000");
      $fatal(1);
   end

endmodule
